// File: rtl/instruction_pair_buffer_if.sv
// Fetch/decode-side bundle for the instruction pair buffer.
// master = fetch/decode environment, slave = the buffer itself.
interface instruction_pair_buffer_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       first_inst_in;
  logic [31:0]       second_inst_in;
  logic [PC_W-1:0]   pc_in;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic [31:0]       first_inst;
  logic [31:0]       second_inst;
  logic [PC_W-1:0]   pc_out;
  logic [CNT_W-1:0]  occupancy;

  modport master (
    output in_valid, first_inst_in, second_inst_in, pc_in, stall, flush,
    input  in_ready, out_valid, first_inst, second_inst, pc_out, occupancy
  );

  modport slave (
    input  in_valid, first_inst_in, second_inst_in, pc_in, stall, flush,
    output in_ready, out_valid, first_inst, second_inst, pc_out, occupancy
  );
endinterface

// File: rtl/instruction_pair_buffer.sv
// Show-ahead FIFO of fetched instruction pairs feeding decode; shows nop/lnop when empty.
// Optional macro IPB_BYPASS_EN: empty-buffer input pair is forwarded to decode in the same cycle.
module instruction_pair_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PC_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  instruction_pair_buffer_if.slave  ipb
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP_INST  = 32'h4020_0000;
  localparam logic [31:0] LNOP_INST = 32'h0020_0000;

  typedef struct packed {
    logic [31:0]     first;
    logic [31:0]     second;
    logic [PC_W-1:0] pc;
  } pair_t;

  pair_t            mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic  empty_c, full_c, bypass_c, push_c, pop_c, head_valid_c;
  pair_t in_pair_c, head_c;

  // Handshake qualification; flush kills both push and pop in the same cycle.
  always_comb begin
    in_pair_c = '{first: ipb.first_inst_in, second: ipb.second_inst_in, pc: ipb.pc_in};
    empty_c   = (count_q == '0);
    full_c    = (count_q == CNT_W'(DEPTH));
`ifdef IPB_BYPASS_EN
    bypass_c  = empty_c & ipb.in_valid & ~ipb.flush;
`else
    bypass_c  = 1'b0;
`endif
    // A bypassed pair consumed by decode this cycle never enters storage.
    push_c    = ipb.in_valid & ~full_c & ~ipb.flush & ~(bypass_c & ~ipb.stall);
    pop_c     = ~empty_c & ~ipb.stall & ~ipb.flush;
  end

  // Pointer and count update.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (ipb.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clock) begin
    if (!reset && push_c) mem_q[wr_ptr_q] <= in_pair_c;
  end

  // Head selection: stored head, else bypassed input, else harmless nop/lnop.
  always_comb begin
    head_valid_c = 1'b0;
    head_c       = '{first: NOP_INST, second: LNOP_INST, pc: '0};
    if (!empty_c) begin
      head_valid_c = 1'b1;
      head_c       = mem_q[rd_ptr_q];
    end else if (bypass_c) begin
      head_valid_c = 1'b1;
      head_c       = in_pair_c;
    end
  end

  assign ipb.in_ready    = ~full_c;
  assign ipb.out_valid   = head_valid_c;
  assign ipb.first_inst  = head_c.first;
  assign ipb.second_inst = head_c.second;
  assign ipb.pc_out      = head_c.pc;
  assign ipb.occupancy   = count_q;

endmodule
